// File: rtl/prescaler.sv
// Free-running 2^N clock prescaler.
// Provides a 50% duty divided clock and a one-cycle all-ones tick.
module prescaler #(
  parameter int N = 16
) (
  input  logic clk,
  input  logic reset,
  output logic out,
  output logic tick
);

  logic [N-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + N'(1);
    end
  end

  // Both outputs come straight from registered state.
  assign out  = r_cnt[N-1];
  assign tick = &r_cnt;

endmodule

// File: tb/tb_prescaler.sv
// Bench for prescaler: vector table, hand corner cases
// and random async-reset stimulus against an edge-count model.
module tb_prescaler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic o4, t4, o1, t1, o12, t12;

  int checks = 0;
  int errors = 0;
  longint e = 0;

  always #5 clk = ~clk;

  prescaler #(.N(4)) u4 (
    .clk(clk), .reset(reset), .out(o4), .tick(t4)
  );
  prescaler #(.N(1)) u1 (
    .clk(clk), .reset(reset), .out(o1), .tick(t1)
  );
  prescaler #(.N(12)) u12 (
    .clk(clk), .reset(reset), .out(o12), .tick(t12)
  );

  // Model: number of rising edges seen since reset released.
  always @(posedge clk or posedge reset) begin
    if (reset) e = 0;
    else e = e + 1;
  end

  function automatic logic m_out(int n, longint k);
    longint p;
    p = longint'(1) << n;
    return (k % p) >= (p / 2);
  endfunction

  function automatic logic m_tick(int n, longint k);
    longint p;
    p = longint'(1) << n;
    return (k % p) == (p - 1);
  endfunction

  task automatic chk(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s e=%0d got %b want %b", name, e, act, exp);
    end
  endtask

  task automatic chk_all(string tag);
    logic r;
    r = reset;
    chk({tag, "_o4"}, o4, r ? 1'b0 : m_out(4, e));
    chk({tag, "_t4"}, t4, r ? 1'b0 : m_tick(4, e));
    chk({tag, "_o1"}, o1, r ? 1'b0 : m_out(1, e));
    chk({tag, "_t1"}, t1, r ? 1'b0 : m_tick(1, e));
    chk({tag, "_o12"}, o12, r ? 1'b0 : m_out(12, e));
    chk({tag, "_t12"}, t12, r ? 1'b0 : m_tick(12, e));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    int   edges;
    logic o4;
    logic t4;
    logic o1;
    logic t1;
  } vec_t;

  vec_t tbl[10];

  int hi_cnt, tk_cnt, rises, gap;
  logic prev;

  initial begin
    tbl[0] = '{0,  1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1,  1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{7,  1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{8,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{14, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{15, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{16, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{24, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{31, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{33, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset held for 3 cycles: everything stays low.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all("rst_hold");
    end

    // Vector table, each from a fresh reset.
    for (int i = 0; i < 10; i++) begin
      pulse_reset();
      repeat (tbl[i].edges) @(posedge clk);
      #2;
      chk("tbl_o4", o4, tbl[i].o4);
      chk("tbl_t4", t4, tbl[i].t4);
      chk("tbl_o1", o1, tbl[i].o1);
      chk("tbl_t1", t1, tbl[i].t1);
    end

    // Division and tick over 64 cycles for N=4.
    pulse_reset();
    hi_cnt = 0;
    tk_cnt = 0;
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk_all("div");
      if (o4) hi_cnt++;
      if (t4) tk_cnt++;
      if (o4 && !prev) rises++;
      prev = o4;
    end
    chk("div_high8of16", hi_cnt == 32, 1'b1);
    chk("tick_count4", tk_cnt == 4, 1'b1);
    chk("rise_count4", rises == 4, 1'b1);

    // Async reset mid-count at cnt=11, between edges.
    pulse_reset();
    repeat (11) @(posedge clk);
    #2;
    chk("pre_rst_o4", o4, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_o4", o4, 1'b0);
    chk("async_t4", t4, 1'b0);
    chk("async_o12", o12, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    gap = 0;
    while (!o4 && gap < 20) begin
      @(posedge clk);
      gap++;
      #1;
    end
    chk("rise_after_8", gap == 8, 1'b1);

    // Wide instance: full wrap of N=12.
    pulse_reset();
    tk_cnt = 0;
    for (int i = 0; i < 4100; i++) begin
      @(negedge clk);
      if (t12) tk_cnt++;
      if (i == 2046 || i == 2047 || i == 4094 || i == 4095)
        chk_all("n12");
    end
    chk("n12_tick_once", tk_cnt == 1, 1'b1);

    // Random run lengths with async resets at random phase.
    for (int it = 0; it < 25; it++) begin
      int len;
      len = $urandom_range(1, 300);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        chk_all("rnd");
      end
      #($urandom_range(1, 3));
      reset = 1'b1;
      #1;
      chk_all("rnd_async");
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        chk_all("rnd_hold");
      end
      reset = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
